// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/mem/writeback sequencer with req/done handshake.
// Optional single-step PAUSE after each writeback when SEQ_SINGLE_STEP_EN is defined.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req,
    input  logic            halt,
    input  logic            mem_op,
    input  logic            reg_write_dec,
    input  logic            mem_write_dec,
    input  logic            mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            pc_reset,
    output logic            ir_load,
    output logic            pc_en,
    output logic            reg_write,
    output logic            mem_req,
    output logic            mem_write,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [2:0]      state,
    output logic [CNTW-1:0] insn_count
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, FETCH = 3'd2, DECODE = 3'd3,
        MEM = 3'd4, WB = 3'd5, DONE = 3'd6, PAUSE = 3'd7
    } state_t;

    localparam int WW = MEM_TIMEOUT > 2 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WLIM = WW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    state_t cur, nxt;
    logic [WW-1:0] wcnt;
    logic tmo;

    // Abort on the last permitted MEM cycle only if memory is still not ready
    assign tmo = (MEM_TIMEOUT > 0) && wcnt == WLIM && !mem_ready;

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:   nxt = req ? START : IDLE;
            START:  nxt = FETCH;
            FETCH:  nxt = DECODE;
            DECODE: nxt = halt ? DONE : mem_op ? MEM : WB;
            MEM:    nxt = mem_ready ? WB : tmo ? DONE : MEM;
`ifdef SEQ_SINGLE_STEP_EN
            WB:     nxt = PAUSE;
            PAUSE:  nxt = step ? FETCH : PAUSE;
`else
            WB:     nxt = FETCH;
`endif
            DONE:   nxt = req ? DONE : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur        <= IDLE;
            wcnt       <= '0;
            insn_count <= '0;
            err        <= 1'b0;
        end else begin
            cur  <= nxt;
            wcnt <= (cur == MEM) ? wcnt + 1'b1 : '0;
            err  <= (cur == START) ? 1'b0 : (cur == MEM && tmo) ? 1'b1 : err;
            if (cur == START)
                insn_count <= '0;
            else if (cur == WB && insn_count != '1)
                insn_count <= insn_count + 1'b1;
        end
    end

    assign pc_reset  = cur == START;
    assign ir_load   = cur == FETCH;
    assign pc_en     = cur == WB;
    assign reg_write = cur == WB && reg_write_dec;
    assign mem_req   = cur == MEM;
    assign mem_write = cur == MEM && mem_write_dec;
    assign busy      = cur inside {START, FETCH, DECODE, MEM, WB, PAUSE};
    assign done      = cur == DONE;
    assign state     = cur;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: cycle-accurate trace checking of cpu_sequencer against a program-level model.
module tb_cpu_sequencer;
    localparam int TO = 4;
    localparam int CW = 4;

    logic clk = 0, reset_n = 0, req = 0, halt = 0, mem_op = 0;
    logic reg_write_dec = 0, mem_write_dec = 0, mem_ready = 0;
    logic pc_reset, ir_load, pc_en, reg_write, mem_req, mem_write, busy, done, err;
    logic [2:0] state;
    logic [CW-1:0] insn_count;

    cpu_sequencer #(.MEM_TIMEOUT(TO), .CNTW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .halt(halt), .mem_op(mem_op),
        .reg_write_dec(reg_write_dec), .mem_write_dec(mem_write_dec), .mem_ready(mem_ready),
        .pc_reset(pc_reset), .ir_load(ir_load), .pc_en(pc_en), .reg_write(reg_write),
        .mem_req(mem_req), .mem_write(mem_write), .busy(busy), .done(done), .err(err),
        .state(state), .insn_count(insn_count)
    );

    always #5 clk = ~clk;

    // stim = {req, halt, mem_op, reg_write_dec, mem_write_dec, mem_ready}
    // fl   = {pc_reset, ir_load, pc_en, reg_write, mem_req, mem_write, busy, done, err}
    typedef struct {
        logic [5:0]    stim;
        logic [8:0]    fl;
        logic [2:0]    st;
        logic [CW-1:0] cnt;
    } vec_t;

    typedef struct {
        logic h, m, rw, mw;
        int   d;
    } ins_t;

    localparam logic [7:0] F_START = 8'b1000_0010;
    localparam logic [7:0] F_FETCH = 8'b0100_0010;
    localparam logic [7:0] F_DEC   = 8'b0000_0010;
    localparam logic [7:0] F_MEM   = 8'b0000_1010;
    localparam logic [7:0] F_WB    = 8'b0010_0010;
    localparam logic [7:0] F_DONE  = 8'b0000_0001;

    vec_t q[$];
    ins_t prog[$];
    int tests = 0, fails = 0;
    logic m_err = 0;
    logic [CW-1:0] m_cnt = 0;

    function automatic vec_t mk(logic [5:0] s, logic [7:0] f, logic e, logic [2:0] st, logic [CW-1:0] c);
        vec_t v;
        v.stim = s;
        v.fl = {f, e};
        v.st = st;
        v.cnt = c;
        return v;
    endfunction

    function automatic logic [15:0] outs();
        return {pc_reset, ir_load, pc_en, reg_write, mem_req, mem_write, busy, done, err, state, insn_count};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic emit(input logic [5:0] s, input logic [7:0] f, input logic [2:0] st);
        q.push_back(mk(s, f, m_err, st, m_cnt));
    endtask

    task automatic run_q();
        foreach (q[i]) begin
            @(posedge clk);
            #1 {req, halt, mem_op, reg_write_dec, mem_write_dec, mem_ready} = q[i].stim;
            #1 check($sformatf("cyc%0d st%0d", i, q[i].st), outs(), {q[i].fl, q[i].st, q[i].cnt});
        end
        q.delete();
    endtask

    // Expected trace of one program run: idle, start, each instruction's phases, done handshake
    task automatic gen(input int idle_n, input int hold_n);
        logic abort;
        logic rdy;
        abort = 0;
        repeat (idle_n) emit({1'b0, 5'($urandom)}, 8'h00, 3'd0);
        emit({1'b1, 5'($urandom)}, 8'h00, 3'd0);
        emit(6'($urandom), F_START, 3'd1);
        m_err = 0;
        m_cnt = 0;
        foreach (prog[i]) begin
            emit(6'($urandom), F_FETCH, 3'd2);
            emit({1'($urandom), prog[i].h, prog[i].m, prog[i].rw, prog[i].mw, 1'($urandom)}, F_DEC, 3'd3);
            if (prog[i].h) break;
            if (prog[i].m) begin
                for (int j = 0; ; j++) begin
                    rdy = (j == prog[i].d);
                    emit({1'($urandom), 1'b0, 1'b1, prog[i].rw, prog[i].mw, rdy},
                         F_MEM | {5'b0, prog[i].mw, 2'b0}, 3'd4);
                    if (rdy) break;
                    if (j == TO - 1) begin
                        m_err = 1;
                        abort = 1;
                        break;
                    end
                end
                if (abort) break;
            end
            emit({1'($urandom), 1'b0, prog[i].m, prog[i].rw, prog[i].mw, 1'($urandom)},
                 F_WB | {3'b0, prog[i].rw, 4'b0}, 3'd5);
            if (m_cnt != '1) m_cnt++;
        end
        repeat (hold_n) emit({1'b1, 5'($urandom)}, F_DONE, 3'd6);
        emit({1'b0, 5'($urandom)}, F_DONE, 3'd6);
        emit({1'b0, 5'($urandom)}, 8'h00, 3'd0);
    endtask

    function automatic ins_t ins(logic h, logic m, logic rw, logic mw, int d);
        ins_t x;
        x.h = h; x.m = m; x.rw = rw; x.mw = mw; x.d = d;
        return x;
    endfunction

    initial begin
        vec_t alu[17];
        int n;
        {req, halt, mem_op, reg_write_dec, mem_write_dec, mem_ready} = 6'b111111;
        #2 check("reset_async", outs(), 16'h0);
        @(posedge clk);
        #1 check("reset_hold", outs(), 16'h0);
        reset_n = 1;
        req = 0;

        alu[0]  = mk(6'b100000, 8'h00,    0, 3'd0, 0);
        alu[1]  = mk(6'b011111, F_START,  0, 3'd1, 0);
        alu[2]  = mk(6'b001111, F_FETCH,  0, 3'd2, 0);
        alu[3]  = mk(6'b000110, F_DEC,    0, 3'd3, 0);
        alu[4]  = mk(6'b000110, 8'h32,    0, 3'd5, 0);
        alu[5]  = mk(6'b111111, F_FETCH,  0, 3'd2, 1);
        alu[6]  = mk(6'b000100, F_DEC,    0, 3'd3, 1);
        alu[7]  = mk(6'b000100, 8'h32,    0, 3'd5, 1);
        alu[8]  = mk(6'b000000, F_FETCH,  0, 3'd2, 2);
        alu[9]  = mk(6'b000100, F_DEC,    0, 3'd3, 2);
        alu[10] = mk(6'b000100, 8'h32,    0, 3'd5, 2);
        alu[11] = mk(6'b011011, F_FETCH,  0, 3'd2, 3);
        alu[12] = mk(6'b111110, F_DEC,    0, 3'd3, 3);
        alu[13] = mk(6'b100000, F_DONE,   0, 3'd6, 3);
        alu[14] = mk(6'b100001, F_DONE,   0, 3'd6, 3);
        alu[15] = mk(6'b000000, F_DONE,   0, 3'd6, 3);
        alu[16] = mk(6'b000000, 8'h00,    0, 3'd0, 3);
        for (int i = 0; i < 17; i++) q.push_back(alu[i]);
        run_q();
        m_cnt = 3;
        m_err = 0;

        prog = '{ins(0, 1, 1, 1, 2), ins(1, 0, 0, 0, 0)};
        gen(2, 1);
        run_q();

        prog = '{ins(0, 0, 1, 0, 0), ins(0, 1, 1, 0, 99), ins(0, 0, 1, 0, 0), ins(1, 0, 0, 0, 0)};
        gen(1, 10);
        run_q();

        prog.delete();
        for (int k = 0; k < 17; k++) prog.push_back(ins(0, 0, 1, 0, 0));
        prog.push_back(ins(1, 0, 0, 0, 0));
        gen(3, 0);
        run_q();

        for (int p = 0; p < 30; p++) begin
            prog.delete();
            n = $urandom_range(1, 24);
            for (int k = 0; k < n; k++)
                prog.push_back(ins((k == n - 1) || ($urandom_range(0, 15) == 0),
                                   $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
                                   $urandom_range(0, 4)));
            gen($urandom_range(0, 3), $urandom_range(0, 4));
            run_q();
        end

        emit(6'b100000, 8'h00, 3'd0);
        emit(6'($urandom), F_START, 3'd1);
        m_err = 0;
        m_cnt = 0;
        emit(6'($urandom), F_FETCH, 3'd2);
        emit(6'b000100, F_DEC, 3'd3);
        emit(6'b000100, 8'h32, 3'd5);
        m_cnt = 1;
        emit(6'($urandom), F_FETCH, 3'd2);
        emit(6'b001010, F_DEC, 3'd3);
        emit(6'b001010, 8'h0E, 3'd4);
        emit(6'b001010, 8'h0E, 3'd4);
        run_q();
        reset_n = 0;
        #1 check("rst_mem_async", outs(), 16'h0);
        mem_ready = 1;
        @(posedge clk);
        #1 check("rst_mem_hold", outs(), 16'h0);
        reset_n = 1;
        req = 0;
        @(posedge clk);
        #1 check("rst_mem_idle", outs(), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
